// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: one result bit per cycle.
// The unit stalls the pipeline while busy and writes back through a one-cycle pulse.
module ex_muldiv #(
    parameter int XLEN         = 32,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic            rd_wen_o,
    output logic            hold_flag_o
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO    = {XLEN{1'b0}};

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_op;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic            r_neg;
    logic            r_special;
    logic [XLEN-1:0] r_result;

    logic            w_start;
    logic            w_is_div;
    logic            w_s1;
    logic            w_s2;
    logic            w_neg1;
    logic            w_neg2;
    logic [XLEN-1:0] w_mag1;
    logic [XLEN-1:0] w_mag2;
    logic            w_div0;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_spec_val;
    logic            w_neg_res;

    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN:0]     w_rem_diff;
    logic [XLEN-1:0]   w_hi_nxt;
    logic [XLEN-1:0]   w_lo_nxt;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_res;

    assign w_start  = (r_state == S_IDLE) & start_i & ~flush_i;
    assign w_is_div = op_i[2];
    assign w_s1     = (op_i == OP_MULH) | (op_i == OP_MULHSU) | (op_i == OP_DIV) | (op_i == OP_REM);
    assign w_s2     = (op_i == OP_MULH) | (op_i == OP_DIV) | (op_i == OP_REM);
    assign w_neg1   = w_s1 & op1_i[XLEN-1];
    assign w_neg2   = w_s2 & op2_i[XLEN-1];
    assign w_mag1   = w_neg1 ? (-op1_i) : op1_i;
    assign w_mag2   = w_neg2 ? (-op2_i) : op2_i;
    assign w_div0   = (op2_i == ZERO);
    assign w_ovf    = ((op_i == OP_DIV) | (op_i == OP_REM)) & (op1_i == MIN_NEG) & (op2_i == ALL_ONE);
    assign w_special = w_is_div & (w_div0 | w_ovf);
    // Quotients carry the xor of operand signs; remainders follow the dividend.
    assign w_neg_res = (w_is_div & op_i[1]) ? w_neg1 : (w_neg1 ^ w_neg2);

    // Architectural results of divide-by-zero and signed overflow.
    always_comb begin
        w_spec_val = ZERO;
        if (w_div0) begin
            w_spec_val = op_i[1] ? op1_i : ALL_ONE;
        end else begin
            w_spec_val = op_i[1] ? ZERO : op1_i;
        end
    end

    // Multiply keeps {partial sum, multiplier} in {r_hi, r_lo}; divide keeps {remainder, quotient}.
    assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : {(XLEN+1){1'b0}});
    assign w_rem_sh   = {r_hi, r_lo[XLEN-1]};
    assign w_rem_diff = w_rem_sh - {1'b0, r_a};

    // One shift-add or restoring-divide step.
    always_comb begin
        w_hi_nxt = r_hi;
        w_lo_nxt = r_lo;
        if (r_op[2]) begin
            if (!w_rem_diff[XLEN]) begin
                w_hi_nxt = w_rem_diff[XLEN-1:0];
                w_lo_nxt = {r_lo[XLEN-2:0], 1'b1};
            end else begin
                w_hi_nxt = w_rem_sh[XLEN-1:0];
                w_lo_nxt = {r_lo[XLEN-2:0], 1'b0};
            end
        end else begin
            {w_hi_nxt, w_lo_nxt} = {w_mul_sum, r_lo[XLEN-1:1]};
        end
    end

    assign w_prod   = {w_hi_nxt, w_lo_nxt};
    assign w_prod_s = r_neg ? (-w_prod) : w_prod;

    // Sign-corrected result selection after the final step.
    always_comb begin
        w_res = ZERO;
        case (r_op)
            OP_MUL:                      w_res = w_prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_res = w_prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             w_res = r_neg ? (-w_lo_nxt) : w_lo_nxt;
            OP_REM, OP_REMU:             w_res = r_neg ? (-w_hi_nxt) : w_hi_nxt;
            default:                     w_res = ZERO;
        endcase
    end

    // Next-state logic; flush overrides every state.
    always_comb begin
        w_state_nxt = r_state;
        if (flush_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        w_state_nxt = (FAST_SPECIAL && w_special) ? S_DONE : S_CALC;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_CALC: begin
                    if (r_cnt == LAST) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_CALC;
                    end
                end
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State, operand capture and iteration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= {CW{1'b0}};
            r_op      <= 3'b000;
            r_rd      <= 5'b00000;
            r_a       <= ZERO;
            r_hi      <= ZERO;
            r_lo      <= ZERO;
            r_neg     <= 1'b0;
            r_special <= 1'b0;
            r_result  <= ZERO;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_op      <= op_i;
                r_rd      <= rd_addr_i;
                r_a       <= w_is_div ? w_mag2 : w_mag1;
                r_lo      <= w_is_div ? w_mag1 : w_mag2;
                r_hi      <= ZERO;
                r_neg     <= w_neg_res;
                r_special <= w_special;
                r_result  <= w_special ? w_spec_val : ZERO;
                r_cnt     <= {CW{1'b0}};
            end else if (r_state == S_CALC) begin
                r_hi  <= w_hi_nxt;
                r_lo  <= w_lo_nxt;
                r_cnt <= r_cnt + CNT_ONE;
                if ((r_cnt == LAST) && !r_special) begin
                    r_result <= w_res;
                end else begin
                    r_result <= r_result;
                end
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    assign rd_wen_o    = (r_state == S_DONE) & ~flush_i;
    assign rd_data_o   = (r_state == S_DONE) ? r_result : ZERO;
    assign rd_addr_o   = (r_state == S_DONE) ? r_rd : 5'b00000;
    assign hold_flag_o = w_start | (r_state == S_CALC);

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomised and directed bench for ex_muldiv: a FAST_SPECIAL=1 and a FAST_SPECIAL=0
// instance share stimulus and are compared every cycle against an arithmetic model.
module tb_ex_muldiv;

    localparam int X = 32;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] op1_i;
    logic [31:0] op2_i;
    logic [4:0]  rd_addr_i;
    logic        flush_i;
    logic [4:0]  rd_addr_f, rd_addr_s;
    logic [31:0] rd_data_f, rd_data_s;
    logic        rd_wen_f, rd_wen_s;
    logic        hold_f, hold_s;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ex_muldiv #(.XLEN(X), .FAST_SPECIAL(1'b1)) dut_f (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .op1_i(op1_i), .op2_i(op2_i),
        .rd_addr_i(rd_addr_i), .flush_i(flush_i), .rd_addr_o(rd_addr_f), .rd_data_o(rd_data_f),
        .rd_wen_o(rd_wen_f), .hold_flag_o(hold_f)
    );

    ex_muldiv #(.XLEN(X), .FAST_SPECIAL(1'b0)) dut_s (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .op1_i(op1_i), .op2_i(op2_i),
        .rd_addr_i(rd_addr_i), .flush_i(flush_i), .rd_addr_o(rd_addr_s), .rd_data_o(rd_data_s),
        .rd_wen_o(rd_wen_s), .hold_flag_o(hold_s)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RV32M semantics from plain wide arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] p;
        logic signed [31:0] sa, sb, sq;
        sa = a;
        sb = b;
        p  = 64'd0;
        sq = 32'sd0;
        case (op)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'd0, b}; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == MINV && b == 32'hFFFF_FFFF) return a;
                sq = sa / sb;
                return sq;
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == MINV && b == 32'hFFFF_FFFF) return 32'd0;
                sq = sa % sb;
                return sq;
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    task automatic chk_cycle(input string tag, input int c, input int lat, input int kill,
                             input bit flush_now, input logic [31:0] exp, input logic [4:0] rd,
                             input logic wen, input logic [31:0] data, input logic [4:0] addr,
                             input logic hold);
        bit in_done;
        in_done = (c == lat) && (c <= kill);
        chk($sformatf("%s_wen_c%0d", tag, c), {63'd0, wen}, {63'd0, in_done && !flush_now});
        chk($sformatf("%s_data_c%0d", tag, c), {32'd0, data}, in_done ? {32'd0, exp} : 64'd0);
        chk($sformatf("%s_addr_c%0d", tag, c), {59'd0, addr}, in_done ? {59'd0, rd} : 64'd0);
        chk($sformatf("%s_hold_c%0d", tag, c), {63'd0, hold}, {63'd0, (c < lat) && (c <= kill)});
    endtask

    // Start one operation in cycle 0 and check both instances every cycle after it.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input int flush_cyc,
                          input int rst_cyc, input int tail, input bit use_lit,
                          input logic [31:0] lit);
        logic [31:0] exp;
        bit spec;
        int lat_f, kill, last;
        exp = ref_res(op, a, b);
        if (use_lit) chk({tag, "_model"}, {32'd0, exp}, {32'd0, lit});
        spec  = op[2] && (b == 32'd0 || (!op[0] && a == MINV && b == 32'hFFFF_FFFF));
        lat_f = spec ? 1 : X + 1;
        kill  = (flush_cyc >= 0) ? flush_cyc : ((rst_cyc >= 0) ? rst_cyc : 1000);
        last  = (kill < 1000) ? kill + tail : X + 2;
        @(posedge clk); #1;
        start_i = 1'b1; op_i = op; op1_i = a; op2_i = b; rd_addr_i = rd;
        flush_i = (flush_cyc == 0); rst = 1'b0;
        @(negedge clk);
        chk({tag, "_hold0_f"}, {63'd0, hold_f}, {63'd0, flush_cyc != 0});
        chk({tag, "_hold0_s"}, {63'd0, hold_s}, {63'd0, flush_cyc != 0});
        for (int c = 1; c <= last; c++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            op_i = 3'($urandom); op1_i = $urandom; op2_i = $urandom; rd_addr_i = 5'($urandom);
            flush_i = (c == flush_cyc);
            rst = (c == rst_cyc);
            @(negedge clk);
            chk_cycle({tag, "_f"}, c, lat_f, kill, c == flush_cyc, exp, rd,
                      rd_wen_f, rd_data_f, rd_addr_f, hold_f);
            chk_cycle({tag, "_s"}, c, X + 1, kill, c == flush_cyc, exp, rd,
                      rd_wen_s, rd_data_s, rd_addr_s, hold_s);
        end
    endtask

    logic [2:0]  d_op  [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] d_a   [12] = '{32'd7, MINV, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                32'd100, 32'd100, 32'd5, 32'd5, MINV, MINV};
    logic [31:0] d_b   [12] = '{32'hFFFF_FFFD, MINV, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                                32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] d_exp [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF,
                                32'd5, MINV, 32'd0};

    initial begin
        rst = 1'b1; start_i = 1'b0; op_i = 3'd0; op1_i = 32'd0; op2_i = 32'd0;
        rd_addr_i = 5'd0; flush_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_wen_f",  {63'd0, rd_wen_f},  64'd0);
        chk("rst_data_f", {32'd0, rd_data_f}, 64'd0);
        chk("rst_addr_f", {59'd0, rd_addr_f}, 64'd0);
        chk("rst_hold_f", {63'd0, hold_f},    64'd0);
        chk("rst_wen_s",  {63'd0, rd_wen_s},  64'd0);
        chk("rst_hold_s", {63'd0, hold_s},    64'd0);

        // Reset wins over a simultaneous start.
        @(posedge clk); #1 rst = 1'b1; start_i = 1'b1; op_i = 3'd0;
        @(posedge clk); #1 rst = 1'b0; start_i = 1'b0;
        @(negedge clk);
        chk("rst_prio_hold", {63'd0, hold_f}, 64'd0);

        for (int i = 0; i < 12; i++)
            run_op($sformatf("dir%0d", i), d_op[i], d_a[i], d_b[i], 5'(i + 1), -1, -1, 0, 1'b1, d_exp[i]);

        run_op("flush_hold", 3'd4, 32'd1000, 32'd3, 5'd9, 10, -1, 3, 1'b0, 32'd0);
        run_op("flush_rst",  3'd4, 32'd1000, 32'd3, 5'd9, 10, -1, 0, 1'b0, 32'd0);
        run_op("restart",    3'd5, 32'd1000, 32'd3, 5'd10, -1, -1, 0, 1'b1, 32'd333);
        run_op("midrst",     3'd0, 32'd12345, 32'd678, 5'd11, -1, 15, 20, 1'b0, 32'd0);
        run_op("st_flush",   3'd0, 32'd3, 32'd4, 5'd12, 0, -1, 5, 1'b0, 32'd0);
        run_op("done_flush", 3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd13, 33, -1, 2, 1'b0, 32'd0);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            int mode, fc;
            op = 3'($urandom_range(0, 7));
            a = $urandom; b = $urandom;
            mode = $urandom_range(0, 9);
            fc = -1;
            if (mode == 0) b = 32'd0;
            if (mode == 1) begin a = MINV; b = 32'hFFFF_FFFF; end
            if (mode == 2) begin a = $urandom_range(0, 20); b = $urandom_range(0, 20); end
            if (mode == 3) b = $urandom_range(1, 9);
            if (mode == 4) a = -a;
            if (mode == 9) fc = $urandom_range(1, 34);
            run_op($sformatf("rnd%0d", i), op, a, b, 5'($urandom), fc, -1, 2, 1'b0, 32'd0);
        end

        @(posedge clk); #1 flush_i = 1'b0; rst = 1'b0; start_i = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand/result width; legal values 8..64.
REQ-002 SHALL have parameter FAST_SPECIAL, default 1: 1 lets divide-by-zero and signed overflow skip CALC.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start_i  input  1  request a new operation; sampled only in IDLE.
REQ-006 SHALL have port op_i  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port op1_i  input  XLEN  rs1 value.
REQ-008 SHALL have port op2_i  input  XLEN  rs2 value.
REQ-009 SHALL have port rd_addr_i  input  5  destination register.
REQ-010 SHALL have port flush_i  input  1  abort from control on a taken jump.
REQ-011 SHALL have port rd_addr_o  output  5  destination register of the completing operation.
REQ-012 SHALL have port rd_data_o  output  XLEN  result.
REQ-013 SHALL have port rd_wen_o  output  1  one-cycle write-enable pulse to regs.
REQ-014 SHALL have port hold_flag_o  output  1  pipeline stall request to control.

Function
REQ-015 SHALL implement the FSM IDLE -> CALC -> DONE -> IDLE.
REQ-016 IDLE with start_i=1 and flush_i=0: capture op_i, rd_addr_i, operand magnitudes and result sign, clear the bit counter, and go to CALC.
REQ-017 CALC SHALL process one bit per cycle, using shift-add for multiply and restoring division for divide, and go to DONE after exactly XLEN cycles.
REQ-018 start_i=1 in cycle 0 SHALL give rd_wen_o=1 in cycle XLEN+1 (cycle 33 for XLEN=32).
REQ-019 DONE SHALL drive rd_wen_o=1, rd_data_o=result and rd_addr_o=captured rd for one cycle, then go unconditionally to IDLE.
REQ-020 Outside DONE, rd_wen_o, rd_data_o and rd_addr_o SHALL be 0.
REQ-021 hold_flag_o SHALL be combinational: (IDLE & start_i & ~flush_i) | CALC; it SHALL be 0 in DONE.
REQ-022 start_i SHALL be ignored in CALC and DONE.
REQ-023 MUL SHALL return the low XLEN bits of the product; MULH, MULHSU and MULHU SHALL return the high XLEN bits.
REQ-024 Operand signedness: signed x signed for MULH, signed x unsigned for MULHSU, unsigned x unsigned for MULHU; the 2*XLEN-bit product SHALL be negated when the operand signs differ.
REQ-025 DIV and REM SHALL use signed operands: the quotient truncates toward zero and the remainder takes the dividend's sign.
REQ-026 Divide by zero SHALL give quotient all-ones and remainder equal to the dividend.
REQ-027 Signed overflow (-2^(XLEN-1) / -1) SHALL give quotient equal to the dividend and remainder 0.
REQ-028 With FAST_SPECIAL=1, the REQ-026/027 cases SHALL go IDLE -> DONE directly, giving rd_wen_o in cycle 1.
REQ-029 With FAST_SPECIAL=0, the REQ-026/027 cases SHALL take full latency with the same results.
REQ-030 flush_i=1 in any state SHALL force IDLE on the next edge.
REQ-031 flush_i=1 in DONE SHALL gate rd_wen_o to 0 in that cycle.
REQ-032 flush_i=1 with start_i=1 in IDLE SHALL ignore the start.

Reset
REQ-033 rst=1 SHALL on the next edge force IDLE and clear the counter and all operand, result and captured-rd registers, taking priority over start_i and flush_i.
REQ-034 After reset, all outputs SHALL be 0, including when rst is asserted mid-CALC; no partial result is written.

Verification
REQ-035 MUL 7 x 0xFFFFFFFD -> rd_data_o=0xFFFFFFEB and rd_wen_o in cycle 33; hold_flag_o high in cycles 0..32.
REQ-036 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-037 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-038 DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, with rd_wen_o in cycle 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
REQ-039 DIV started in cycle 0 with flush_i=1 in cycle 10: no rd_wen_o, hold_flag_o=0 in cycle 11, and a new start in cycle 11 completes in cycle 44.
REQ-040 rst=1 in cycle 15 of a MUL: IDLE in cycle 16, all outputs 0, and no rd_wen_o pulse afterwards.
